multicycle_control_fsm: RTL

// - Sequencing controller for the multi-cycle RV32I datapath: one instruction over several states.
// - Covers opcodes R-type 0110011, I-ALU 0010011, load 0000011, store 0100011, branch 1100011.
// - Drives the register-file, ALU-mux, memory and PC enables, and waits on a shared memory ready handshake.
// - Raises a sticky trap on an illegal opcode or a memory timeout.

---
 rtl/multicycle_control_fsm_pkg.sv | 54 +++++
 rtl/multicycle_control_fsm_mem_wait_timer.sv | 37 +++
 rtl/multicycle_control_fsm.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// ============================================================================
// Module  : riscv_ctrl_pkg
// Purpose : Shared state, opcode and mux-select encodings for the RV32I
//           multi-cycle sequencing controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEM_ADDR = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_MEM_WB   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_EXEC_R   = 4'd7,
        ST_EXEC_I   = 4'd8,
        ST_ALU_WB   = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_TRAP     = 4'd11
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_RS1   = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic PCSRC_ALU    = 1'b0;
    localparam logic PCSRC_ALUOUT = 1'b1;

    // States that stall on the shared memory handshake and are timed out.
    function automatic logic is_wait_state(input state_e s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_control_fsm_mem_wait_timer.sv
// ============================================================================
// Module  : mem_wait_timer
// Purpose : Counts stalled cycles in a memory wait state; flags the last one.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TW          = 5
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam logic [TW-1:0] C_LIMIT = TW'(MEM_TIMEOUT - 1);

    logic [TW-1:0] count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (inc_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired_o = (count_q == C_LIMIT);

endmodule

`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
// ============================================================================
// Module  : multicycle_control_fsm
// Purpose : Multi-cycle RV32I control sequencer with memory-wait timeout trap.
// Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_control_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TW          = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       pc_source,
    output logic       instr_done,
    output logic       trap,
    output logic [3:0] state_dbg
);

    state_e state_q;
    state_e state_d;
    logic   timer_clear;
    logic   timer_inc;
    logic   timer_expired;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TW          (TW)
    ) u_timer (
        .clk_i     (clk),
        .rst_i     (reset),
        .clear_i   (timer_clear),
        .inc_i     (timer_inc),
        .expired_o (timer_expired)
    );

    // Any state change clears the timer, so every wait state starts at zero.
    assign timer_clear = (state_d != state_q);
    assign timer_inc   = is_wait_state(state_q) && !mem_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     state_d = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready)          state_d = ST_DECODE;
                else if (timer_expired) state_d = ST_TRAP;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = ST_MEM_ADDR;
                    OP_R:              state_d = ST_EXEC_R;
                    OP_I:              state_d = ST_EXEC_I;
                    OP_BRANCH:         state_d = ST_BRANCH;
                    default:           state_d = ST_TRAP;
                endcase
            end
            ST_MEM_ADDR: begin
                if (opcode == OP_LOAD)       state_d = ST_MEM_RD;
                else if (opcode == OP_STORE) state_d = ST_MEM_WR;
                else                         state_d = ST_TRAP;
            end
            ST_MEM_RD: begin
                if (mem_ready)          state_d = ST_MEM_WB;
                else if (timer_expired) state_d = ST_TRAP;
            end
            ST_MEM_WB:   state_d = ST_FETCH;
            ST_MEM_WR: begin
                if (mem_ready)          state_d = ST_FETCH;
                else if (timer_expired) state_d = ST_TRAP;
            end
            ST_EXEC_R:   state_d = ST_ALU_WB;
            ST_EXEC_I:   state_d = ST_ALU_WB;
            ST_ALU_WB:   state_d = ST_FETCH;
            ST_BRANCH:   state_d = ST_FETCH;
            ST_TRAP:     state_d = ST_TRAP;
            default:     state_d = ST_TRAP;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALUOP_ADD;
        pc_source     = PCSRC_ALU;
        instr_done    = 1'b0;
        trap          = 1'b0;
        case (state_q)
            ST_IDLE: ;
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            ST_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            ST_MEM_ADDR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            ST_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            ST_MEM_WR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            ST_EXEC_R: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_FUNCT;
            end
            ST_EXEC_I: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            ST_ALU_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a     = SRCA_RS1;
                alu_src_b     = SRCB_RS2;
                alu_op        = ALUOP_BRANCH;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                instr_done    = 1'b1;
            end
            ST_TRAP:  trap = 1'b1;
            default:  trap = 1'b1;
        endcase
    end

    assign state_dbg = state_q;

endmodule

`default_nettype wire
